rf_wb_queue: RTL

- Write-side initiator for the CPU register file.
- Accepts register write requests from two producers:
  - A: the main datapath, with priority.
  - B: long-latency units (load/MDU).
- Buffers requests in a small FIFO and drives the register file's single write port (write-enable, write address, write data), one write per cycle, in order.
- Exposes a pending-write scoreboard with optional bypass data so readers can stall or forward.

---
 rtl/rf_wb_pkg.sv | 24 ++
 rtl/rf_wb_queue_if.sv | 46 ++++
 rtl/rf_wb_fifo.sv | 81 ++++++++
 rtl/rf_wb_queue.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// ============================================================================
// Package : rf_wb_pkg
// Shared widths, the write-back entry type and the zero-register constant
// used by the register-file write-back queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_wb_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_XLEN = 32;

    typedef struct packed {
        logic [RF_AW-1:0]   addr;
        logic [RF_XLEN-1:0] data;
    } wb_entry_t;

    // Writes to the hard-wired zero register are dropped at the door.
    localparam logic [RF_AW-1:0] REG_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/rf_wb_queue_if.sv
// ============================================================================
// Interface : rf_wb_queue_if
// Producer handshakes, register-file write port and scoreboard query bus
// of the write-back queue. slave = queue side, master = environment side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_wb_queue_if
    import rf_wb_pkg::*;
#(
    parameter int AW   = RF_AW,
    parameter int XLEN = RF_XLEN
);
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_addr;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_addr;
    logic [XLEN-1:0] b_data;
    logic            rf_wr;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd;
    logic [AW-1:0]   q1_addr;
    logic [AW-1:0]   q2_addr;
    logic            q1_hit;
    logic            q2_hit;
    logic [XLEN-1:0] q1_data;
    logic [XLEN-1:0] q2_data;
    logic            idle;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q1_addr, q2_addr,
        output a_ready, b_ready, rf_wr, rf_a3, rf_wd, q1_hit, q2_hit, q1_data, q2_data, idle
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q1_addr, q2_addr,
        input  a_ready, b_ready, rf_wr, rf_a3, rf_wd, q1_hit, q2_hit, q1_data, q2_data, idle
    );

endinterface

`default_nettype wire

// File: rtl/rf_wb_fifo.sv
// ============================================================================
// Module  : rf_wb_fifo
// Two-write / one-read circular buffer with occupancy count. All entries are
// presented oldest-first (index 0 = head) with a valid mask so the owner can
// scan them for pending-write hazards.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int XLEN  = RF_XLEN,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push0_i,
    input  wire logic [AW-1:0]              push0_addr_i,
    input  wire logic [XLEN-1:0]            push0_data_i,
    input  wire logic                       push1_i,
    input  wire logic [AW-1:0]              push1_addr_i,
    input  wire logic [XLEN-1:0]            push1_data_i,
    input  wire logic                       pop_i,
    output logic      [CW-1:0]              count_o,
    output logic      [DEPTH-1:0]           valid_o,
    output logic      [DEPTH-1:0][AW-1:0]   addr_o,
    output logic      [DEPTH-1:0][XLEN-1:0] data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]   addr_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   wr_ptr_p1;

    assign wr_ptr_p1 = wr_ptr_q + PW'(1);
    assign count_o   = count_q;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so wrap is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push0_i) + PW'(push1_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_i);
            count_q  <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
        end
    end

    // Storage; second push always lands right behind the first.
    always_ff @(posedge clk) begin
        if (push0_i) begin
            addr_mem[wr_ptr_q] <= push0_addr_i;
            data_mem[wr_ptr_q] <= push0_data_i;
        end
        if (push1_i) begin
            addr_mem[wr_ptr_p1] <= push1_addr_i;
            data_mem[wr_ptr_p1] <= push1_data_i;
        end
    end

    // Age-ordered view of the buffer, head first.
    for (genvar k = 0; k < DEPTH; k++) begin : g_view
        logic [PW-1:0] idx;
        assign idx        = rd_ptr_q + PW'(k);
        assign addr_o[k]  = addr_mem[idx];
        assign data_o[k]  = data_mem[idx];
        assign valid_o[k] = (CW'(k) < count_q);
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_queue.sv
// ============================================================================
// Module  : rf_wb_queue
// Register-file write-back initiator. Merges a priority producer (A) and a
// long-latency producer (B) into an in-order FIFO that drains one write per
// cycle into the register-file write port, and answers two pending-write
// scoreboard queries.
// Build option: RF_WB_FWD_EN - when defined, queries also return the data of
// the youngest pending write; otherwise query data is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = RF_XLEN,
    parameter int AW    = RF_AW
) (
    input  wire logic    clk,
    input  wire logic    rst,
    rf_wb_queue_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef RF_WB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [CW-1:0]              count;
    logic [CW-1:0]              free;
    logic [DEPTH-1:0]           ent_valid;
    logic [DEPTH-1:0][AW-1:0]   ent_addr;
    logic [DEPTH-1:0][XLEN-1:0] ent_data;
    logic                       acc_a, acc_b, enq_a, enq_b, pop;
    logic                       push0, push1;
    logic [AW-1:0]              push0_addr;
    logic [XLEN-1:0]            push0_data;

    logic                       rf_wr_q, rf_wr_d;
    logic [AW-1:0]              rf_a3_q, rf_a3_d;
    logic [XLEN-1:0]            rf_wd_q, rf_wd_d;

    // Readiness uses start-of-cycle occupancy only; a same-cycle pop is not
    // credited, which keeps ready off the pop path.
    assign free        = CW'(DEPTH) - count;
    assign bus.a_ready = (free >= CW'(1));
    assign bus.b_ready = (free >= (bus.a_valid ? CW'(2) : CW'(1)));

    assign acc_a = bus.a_valid && bus.a_ready;
    assign acc_b = bus.b_valid && bus.b_ready;
    assign enq_a = acc_a && (bus.a_addr != AW'(REG_ZERO));
    assign enq_b = acc_b && (bus.b_addr != AW'(REG_ZERO));

    // A is always the older of a same-cycle pair.
    assign push0      = enq_a || enq_b;
    assign push0_addr = enq_a ? bus.a_addr : bus.b_addr;
    assign push0_data = enq_a ? bus.a_data : bus.b_data;
    assign push1      = enq_a && enq_b;
    assign pop        = (count != '0);

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (push0),
        .push0_addr_i (push0_addr),
        .push0_data_i (push0_data),
        .push1_i      (push1),
        .push1_addr_i (bus.b_addr),
        .push1_data_i (bus.b_data),
        .pop_i        (pop),
        .count_o      (count),
        .valid_o      (ent_valid),
        .addr_o       (ent_addr),
        .data_o       (ent_data)
    );

    // Next write-port contents: load the head on a pop, otherwise hold address/data.
    always_comb begin
        rf_wr_d = pop;
        rf_a3_d = rf_a3_q;
        rf_wd_d = rf_wd_q;
        if (pop) begin
            rf_a3_d = ent_addr[0];
            rf_wd_d = ent_data[0];
        end
    end

    // Register-file write port register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_q <= 1'b0;
            rf_a3_q <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_wr_q <= rf_wr_d;
            rf_a3_q <= rf_a3_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign bus.rf_wr = rf_wr_q;
    assign bus.rf_a3 = rf_a3_q;
    assign bus.rf_wd = rf_wd_q;
    assign bus.idle  = (count == '0) && !rf_wr_q;

    // One scoreboard lookup per query port; index 0 = q1, index 1 = q2.
    for (genvar n = 0; n < 2; n++) begin : g_sb
        logic [AW-1:0]   qaddr;
        logic            hit;
        logic [XLEN-1:0] data;

        assign qaddr = (n == 0) ? bus.q1_addr : bus.q2_addr;

        // Scan oldest to youngest so the last match left standing is the youngest.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (rf_wr_q && (rf_a3_q == qaddr)) begin
                hit  = 1'b1;
                data = rf_wd_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (ent_valid[k] && (ent_addr[k] == qaddr)) begin
                    hit  = 1'b1;
                    data = ent_data[k];
                end
            end
            if (qaddr == AW'(REG_ZERO)) begin
                hit  = 1'b0;
                data = '0;
            end
            if (!FWD_EN) begin
                data = '0;
            end
        end
    end

    assign bus.q1_hit  = g_sb[0].hit;
    assign bus.q1_data = g_sb[0].data;
    assign bus.q2_hit  = g_sb[1].hit;
    assign bus.q2_data = g_sb[1].data;

endmodule

`default_nettype wire
